rbe_binconv_act_buffer: RTL and testbench
=========================================

RBE_BINCONV_ACT_BUFFER -- requirements
Module: rbe_binconv_act_buffer

Interface
REQ-001 Parameter TP, default 32: bits per activation word.
REQ-002 Parameter BLOCK_SIZE, default 4: words per pixel (one per SoP).
REQ-003 Parameter OUT_H, default 3: output rows of columns.
REQ-004 Parameter OUT_W, default 3: output columns of columns; NR_COLUMN = OUT_H*OUT_W.
REQ-005 Parameter FS_MAX, default 3, odd: max filter size; COLUMN_SIZE = FS_MAX*FS_MAX, TILE_H = OUT_H+FS_MAX-1, TILE_W = OUT_W+FS_MAX-1, NR_PIX = TILE_H*TILE_W.
REQ-006 clk_i  input  1  clock; all state updates on the rising edge.
REQ-007 rst_i  input  1  asynchronous, active-high reset.
REQ-008 clear_i  input  1  synchronous soft clear.
REQ-009 start_i  input  1  start a load/stream job (sampled in IDLE only).
REQ-010 fs1_i  input  1  1 = filter size 1, 0 = filter size FS_MAX; latched at start.
REQ-011 n_replay_i  input  16  number of output handshakes per job; latched at start.
REQ-012 act_valid_i / act_ready_o  input / output  1  activation pixel handshake.
REQ-013 act_data_i  input  BLOCK_SIZE*TP  one pixel; word b at bits [b*TP +: TP].
REQ-014 map_valid_o / map_ready_i  output / input  1  mapped-array handshake.
REQ-015 map_data_o  output  NR_COLUMN*COLUMN_SIZE*BLOCK_SIZE*TP  word (c,r,b) at index (c*COLUMN_SIZE+r)*BLOCK_SIZE+b.
REQ-016 busy_o  output  1  state != IDLE.
REQ-017 done_o  output  1  one-cycle pulse at job completion.

Function
REQ-018 FSM states IDLE, LOAD, STREAM; IDLE & start_i -> LOAD, latching fs1_i and n_replay_i (0 treated as 1), load and replay counters zeroed.
REQ-019 Load count: fs1 -> OUT_H*OUT_W pixels in an OUT_H x OUT_W window; else NR_PIX pixels in TILE_H x TILE_W.
REQ-020 act_ready_o = 1 only in LOAD; each act handshake writes the pixel at buffer address row*TILE_W+col, row-major, col wrapping at window width (OUT_W if fs1, else TILE_W).
REQ-021 The cycle after the last load handshake the FSM enters STREAM; map_valid_o = 1 throughout STREAM, and map_data_o is stable while map_valid_o & !map_ready_i.
REQ-022 Mapping for column c = oi*OUT_W+oj, row r = fi*FS_MAX+fj: full mode -> pixel (oi+fi, oj+fj); fs1 mode -> pixel (oi, oj) for every r.
REQ-023 Each map handshake increments the replay counter; on the n_replay-th handshake FSM -> IDLE and done_o pulses in the following cycle.
REQ-024 map_data_o outside STREAM reflects current buffer contents; map_valid_o = 0.
REQ-025 start_i outside IDLE is ignored; act_valid_i outside LOAD is not acknowledged.
REQ-026 clear_i: FSM -> IDLE, counters -> 0, done_o not asserted, buffer contents retained; clear_i wins over simultaneous start_i or handshakes.
REQ-027 Counter arithmetic unsigned; load counter width $clog2(NR_PIX+1), replay counter 16 bits, no overflow possible by construction.

Reset
REQ-028 On rst_i: FSM IDLE, all counters 0, buffer all zero, act_ready_o = 0, map_valid_o = 0, busy_o = 0, done_o = 0, latched fs1 = 0, latched n_replay = 1.
REQ-029 Reset asserted mid-job aborts immediately; no done_o pulse is generated.

Structure
REQ-030 rbe_package SHALL hold the state enum act_buf_state_e and ctrl_act_buffer_t {fs1, n_replay}.
REQ-031 Mapping crossbar SHALL be one combinational sub-module rbe_act_window_map; FSM, counters and buffer stay in the top.

Verification
REQ-032 Full mode, 25 pixels with word b of pixel p = {p,b}, n_replay=2, map_ready_i=1 -> map_valid_o first high cycle after 25th beat, column 4 row 8 word 0 = pixel 18, exactly 2 handshakes, done_o one cycle later.
REQ-033 fs1 mode, 9 pixels -> act_ready_o drops after 9th beat; column 5, every row, carries pixel index 1*TILE_W+2 = 7.
REQ-034 Backpressure: map_ready_i toggling 1010..., n_replay=4 -> map_data_o stable while stalled, done_o after exactly 4 handshakes.
REQ-035 clear_i asserted at load beat 10 together with start_i -> IDLE, busy_o=0, no done_o; next job loads 25 fresh pixels correctly.
REQ-036 rst_i asserted in STREAM -> all outputs at reset values same cycle asynchronously, buffer reads zero.
REQ-037 n_replay_i=0 -> exactly one map handshake, then done_o.

Source files
------------

// File: rtl/rbe_package.sv
// rbe_package: shared state and control types for the binconv activation buffer
package rbe_package;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} act_buf_state_e;
  typedef struct packed {
    logic        fs1;
    logic [15:0] n_replay;
  } ctrl_act_buffer_t;
endpackage

// File: rtl/rbe_act_window_map.sv
// rbe_act_window_map: combinational crossbar from the pixel tile to per-column filter windows
module rbe_act_window_map #(
  parameter int TP = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int OUT_H = 3,
  parameter int OUT_W = 3,
  parameter int FS_MAX = 3,
  localparam int PW = BLOCK_SIZE*TP,
  localparam int TILE_W = OUT_W+FS_MAX-1,
  localparam int NR_PIX = (OUT_H+FS_MAX-1)*TILE_W,
  localparam int COLUMN_SIZE = FS_MAX*FS_MAX,
  localparam int NR_COLUMN = OUT_H*OUT_W
) (
  input  logic                                fs1,
  input  logic [NR_PIX*PW-1:0]                buffer,
  output logic [NR_COLUMN*COLUMN_SIZE*PW-1:0] map_data
);
  for (genvar i = 0; i < OUT_H; i++) begin : g_oi
    for (genvar j = 0; j < OUT_W; j++) begin : g_oj
      for (genvar k = 0; k < FS_MAX; k++) begin : g_fi
        for (genvar l = 0; l < FS_MAX; l++) begin : g_fj
          localparam int C = i*OUT_W+j;
          localparam int R = k*FS_MAX+l;
          localparam int P_FULL = (i+k)*TILE_W+j+l;
          localparam int P_FS1 = i*TILE_W+j;
          // filter size 1 broadcasts the centre-less single pixel to every row of the column
          assign map_data[(C*COLUMN_SIZE+R)*PW +: PW] = fs1 ? buffer[P_FS1*PW +: PW] : buffer[P_FULL*PW +: PW];
        end
      end
    end
  end
endmodule

// File: rtl/rbe_binconv_act_buffer.sv
// rbe_binconv_act_buffer: loads an activation tile, then replays its windowed mapping n_replay times
module rbe_binconv_act_buffer
  import rbe_package::*;
#(
  parameter int TP = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int OUT_H = 3,
  parameter int OUT_W = 3,
  parameter int FS_MAX = 3
) (
  input  logic                                                            clk_i,
  input  logic                                                            rst_i,
  input  logic                                                            clear_i,
  input  logic                                                            start_i,
  input  logic                                                            fs1_i,
  input  logic [15:0]                                                     n_replay_i,
  input  logic                                                            act_valid_i,
  output logic                                                            act_ready_o,
  input  logic [BLOCK_SIZE*TP-1:0]                                        act_data_i,
  output logic                                                            map_valid_o,
  input  logic                                                            map_ready_i,
  output logic [OUT_H*OUT_W*FS_MAX*FS_MAX*BLOCK_SIZE*TP-1:0]              map_data_o,
  output logic                                                            busy_o,
  output logic                                                            done_o
);
  localparam int PW = BLOCK_SIZE*TP;
  localparam int TILE_H = OUT_H+FS_MAX-1;
  localparam int TILE_W = OUT_W+FS_MAX-1;
  localparam int NR_PIX = TILE_H*TILE_W;
  localparam int LCW = $clog2(NR_PIX+1);
  act_buf_state_e state;
  ctrl_act_buffer_t ctrl;
  logic [LCW-1:0] load_cnt, row_cnt, col_cnt, load_total, win_w, addr;
  logic [15:0] replay_cnt;
  logic [NR_PIX*PW-1:0] buffer;
  logic act_hs, map_hs, load_last, col_last, replay_last;
  assign act_ready_o = state == LOAD;
  assign map_valid_o = state == STREAM;
  assign busy_o = state != IDLE;
  assign act_hs = act_valid_i & act_ready_o;
  assign map_hs = map_valid_o & map_ready_i;
  assign load_total = ctrl.fs1 ? LCW'(OUT_H*OUT_W) : LCW'(NR_PIX);
  assign win_w = ctrl.fs1 ? LCW'(OUT_W) : LCW'(TILE_W);
  assign load_last = load_cnt == load_total - 1'b1;
  assign col_last = col_cnt == win_w - 1'b1;
  assign replay_last = replay_cnt == ctrl.n_replay - 16'd1;
  assign addr = row_cnt * LCW'(TILE_W) + col_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      ctrl <= '{fs1: 1'b0, n_replay: 16'd1};
      load_cnt <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      replay_cnt <= '0;
      buffer <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (clear_i) begin
        state <= IDLE;
        load_cnt <= '0;
        row_cnt <= '0;
        col_cnt <= '0;
        replay_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            state <= LOAD;
            ctrl <= '{fs1: fs1_i, n_replay: (n_replay_i == 16'd0) ? 16'd1 : n_replay_i};
            load_cnt <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            replay_cnt <= '0;
          end
          LOAD: if (act_hs) begin
            buffer[addr*PW +: PW] <= act_data_i;
            load_cnt <= load_cnt + 1'b1;
            col_cnt <= col_last ? '0 : col_cnt + 1'b1;
            row_cnt <= row_cnt + LCW'(col_last);
            if (load_last) state <= STREAM;
          end
          STREAM: if (map_hs) begin
            replay_cnt <= replay_last ? 16'd0 : replay_cnt + 16'd1;
            if (replay_last) begin
              state <= IDLE;
              done_o <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  rbe_act_window_map #(
    .TP(TP), .BLOCK_SIZE(BLOCK_SIZE), .OUT_H(OUT_H), .OUT_W(OUT_W), .FS_MAX(FS_MAX)
  ) u_map (
    .fs1(ctrl.fs1),
    .buffer(buffer),
    .map_data(map_data_o)
  );
endmodule

// File: tb/tb_rbe_binconv_act_buffer.sv
// tb_rbe_binconv_act_buffer: randomized scenario bench against a tile/window reference model
module tb_rbe_binconv_act_buffer;
  localparam int TP = 32, BS = 4, OH = 3, OW = 3, FS = 3;
  localparam int TH = OH+FS-1, TW = OW+FS-1, NP = TH*TW, NC = OH*OW, CS = FS*FS;
  localparam int PW = BS*TP, MW = NC*CS*PW;
  logic clk = 1'b0, rst, clear, start, fs1, act_valid, act_ready, map_valid, map_ready, busy, done;
  logic [15:0] n_replay;
  logic [PW-1:0] act_data;
  logic [MW-1:0] map_data;
  logic [PW-1:0] pix [NP];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  rbe_binconv_act_buffer dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .fs1_i(fs1),
    .n_replay_i(n_replay), .act_valid_i(act_valid), .act_ready_o(act_ready),
    .act_data_i(act_data), .map_valid_o(map_valid), .map_ready_i(map_ready),
    .map_data_o(map_data), .busy_o(busy), .done_o(done)
  );
  function automatic logic [MW-1:0] expected_map(input logic f);
    logic [MW-1:0] e;
    int p;
    e = '0;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < CS; r++) begin
        p = f ? (c/OW)*TW + c%OW : (c/OW + r/FS)*TW + c%OW + r%FS;
        e[(c*CS+r)*PW +: PW] = pix[p];
      end
    return e;
  endfunction
  function automatic int first_diff(input logic [MW-1:0] a, input logic [MW-1:0] b);
    for (int i = 0; i < MW/TP; i++)
      if (a[i*TP +: TP] !== b[i*TP +: TP]) return i;
    return -1;
  endfunction
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic start_job(input logic f, input logic [15:0] n);
    start = 1'b1; fs1 = f; n_replay = n;
    tick;
    start = 1'b0; fs1 = 1'($urandom); n_replay = 16'($urandom);
  endtask
  task automatic load(input logic f, input int count, input bit seq);
    int a, w;
    for (int k = 0; k < count; k++) begin
      while ($urandom_range(0, 3) == 0) begin
        act_valid = 1'b0; act_data = {4{32'($urandom)}}; start = 1'($urandom);
        tick;
      end
      a = f ? (k/OW)*TW + k%OW : k;
      act_valid = 1'b1;
      for (int b = 0; b < BS; b++) act_data[b*TP +: TP] = seq ? {16'(a), 16'(b)} : 32'($urandom);
      w = 0;
      while (!act_ready && w < 20) begin tick; w++; end
      if (w == 20) begin
        total++;
        $display("FAIL load_ready_timeout beat %0d act_ready=%b required 1", k, act_ready);
      end
      pix[a] = act_data;
      tick;
    end
    act_valid = 1'b0; start = 1'b0;
  endtask
  task automatic stream(input int n, input bit toggle, input string name);
    int hs = 0, cyc = 0;
    logic [MW-1:0] prev;
    bit stalled = 0, bad_valid = 0, bad_stable = 0, early_done = 0;
    prev = map_data;
    while (hs < n && cyc < 200) begin
      map_ready = toggle ? ~cyc[0] : 1'b1;
      if (!map_valid) bad_valid = 1;
      if (done) early_done = 1;
      if (stalled && map_data !== prev) bad_stable = 1;
      stalled = map_valid && !map_ready;
      prev = map_data;
      if (map_valid && map_ready) hs++;
      tick;
      cyc++;
    end
    map_ready = 1'b0;
    total++;
    if (hs !== n) $display("FAIL %s_handshakes got %0d required %0d", name, hs, n); else passed++;
    total++;
    if (bad_valid || bad_stable || early_done)
      $display("FAIL %s_stream valid_drop=%b unstable=%b early_done=%b required 0 0 0", name, bad_valid, bad_stable, early_done);
    else passed++;
    total++;
    if ({done, map_valid, busy} !== 3'b100) $display("FAIL %s_done_pulse done/valid/busy=%b required 100", name, {done, map_valid, busy}); else passed++;
    tick;
    total++;
    if (done !== 1'b0) $display("FAIL %s_done_width done=%b required 0", name, done); else passed++;
  endtask
  task automatic test_reset;
    int d;
    act_valid = 1'b1;
    tick;
    total++;
    if ({act_ready, map_valid, busy, done} !== 4'b0000)
      $display("FAIL reset_outputs ready/valid/busy/done=%b required 0000", {act_ready, map_valid, busy, done});
    else passed++;
    d = first_diff(map_data, '0);
    total++;
    if (d >= 0) $display("FAIL reset_buffer word %0d got %h required 0", d, map_data[d*TP +: TP]); else passed++;
    act_valid = 1'b0;
  endtask
  task automatic test_full;
    int d;
    logic [TP-1:0] w18;
    start_job(1'b0, 16'd2);
    total++;
    if ({busy, act_ready} !== 2'b11) $display("FAIL full_start busy/ready=%b required 11", {busy, act_ready}); else passed++;
    load(1'b0, NP, 1'b1);
    total++;
    if ({map_valid, act_ready} !== 2'b10) $display("FAIL full_enter_stream valid/ready=%b required 10", {map_valid, act_ready}); else passed++;
    d = first_diff(map_data, expected_map(1'b0));
    total++;
    if (d >= 0) $display("FAIL full_map word %0d got %h required %h", d, map_data[d*TP +: TP], expected_map(1'b0) >> (d*TP)); else passed++;
    w18 = map_data[((4*CS+8)*BS+0)*TP +: TP];
    total++;
    if (w18 !== {16'd18, 16'd0}) $display("FAIL full_c4_r8 got %h required %h", w18, {16'd18, 16'd0}); else passed++;
    stream(2, 1'b0, "full");
  endtask
  task automatic test_fs1;
    int d;
    bit bad = 0;
    logic [15:0] n;
    n = 16'($urandom_range(1, 3));
    start_job(1'b1, n);
    load(1'b1, NC, 1'b0);
    total++;
    if ({map_valid, act_ready} !== 2'b10) $display("FAIL fs1_enter_stream valid/ready=%b required 10", {map_valid, act_ready}); else passed++;
    d = first_diff(map_data, expected_map(1'b1));
    total++;
    if (d >= 0) $display("FAIL fs1_map word %0d got %h", d, map_data[d*TP +: TP]); else passed++;
    for (int r = 0; r < CS; r++) if (map_data[(5*CS+r)*PW +: PW] !== pix[1*TW+2]) bad = 1;
    total++;
    if (bad) $display("FAIL fs1_column5 got %h required %h", map_data[(5*CS)*PW +: TP], pix[7][TP-1:0]); else passed++;
    stream(int'(n), 1'b0, "fs1");
  endtask
  task automatic test_backpressure;
    start_job(1'b0, 16'd4);
    load(1'b0, NP, 1'b0);
    stream(4, 1'b1, "backpressure");
  endtask
  task automatic test_clear;
    int d;
    bit seen = 0;
    start_job(1'b0, 16'd3);
    load(1'b0, 10, 1'b0);
    act_valid = 1'b1; act_data = {4{32'($urandom)}}; clear = 1'b1; start = 1'b1;
    tick;
    clear = 1'b0; start = 1'b0; act_valid = 1'b0;
    total++;
    if ({busy, act_ready, done} !== 3'b000) $display("FAIL clear_state busy/ready/done=%b required 000", {busy, act_ready, done}); else passed++;
    d = first_diff(map_data, expected_map(1'b0));
    total++;
    if (d >= 0) $display("FAIL clear_retain word %0d got %h", d, map_data[d*TP +: TP]); else passed++;
    for (int i = 0; i < 5; i++) begin if (done || busy) seen = 1; tick; end
    total++;
    if (seen) $display("FAIL clear_idle saw done/busy=1 required 0"); else passed++;
    start_job(1'b0, 16'd1);
    load(1'b0, NP, 1'b0);
    d = first_diff(map_data, expected_map(1'b0));
    total++;
    if (d >= 0) $display("FAIL clear_reload word %0d got %h", d, map_data[d*TP +: TP]); else passed++;
    stream(1, 1'b0, "clear_reload");
  endtask
  task automatic test_zero_replay;
    start_job(1'b0, 16'd0);
    load(1'b0, NP, 1'b0);
    stream(1, 1'b0, "zero_replay");
  endtask
  task automatic test_reset_stream;
    int d;
    start_job(1'b0, 16'd3);
    load(1'b0, NP, 1'b0);
    map_ready = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({act_ready, map_valid, busy, done} !== 4'b0000)
      $display("FAIL rst_stream_outputs ready/valid/busy/done=%b required 0000", {act_ready, map_valid, busy, done});
    else passed++;
    d = first_diff(map_data, '0);
    total++;
    if (d >= 0) $display("FAIL rst_stream_buffer word %0d got %h required 0", d, map_data[d*TP +: TP]); else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NP; i++) pix[i] = '0;
    tick;
    total++;
    if ({done, busy} !== 2'b00) $display("FAIL rst_stream_after done/busy=%b required 00", {done, busy}); else passed++;
  endtask
  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; fs1 = 1'b0; n_replay = '0;
    act_valid = 1'b0; act_data = '0; map_ready = 1'b0;
    for (int i = 0; i < NP; i++) pix[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_full;
    test_fs1;
    test_backpressure;
    test_clear;
    test_zero_replay;
    test_reset_stream;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
